// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter that hands the shared uio pad bank to one requester at a time,
// inserting an all-oe-low turnaround gap between owners. Optional macro: UIO_ARB_TIMEOUT_EN.
module uio_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   rel,
  input  logic [8*NUM_REQ-1:0] req_dout,
  input  logic [8*NUM_REQ-1:0] req_doe,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   winner, winner_d, last_owner;
  logic [3:0]         turn_cnt;
  logic               req_own, rel_own, forced;
  logic [7:0]         own_dout, own_doe;
  logic [NUM_REQ-1:0] gnt_d;
  logic [7:0]         uio_out_d, uio_oe_d;
  logic               timeout_d;

  // First set request strictly after the previous owner, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && r[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign req_own = req[winner];
  assign rel_own = rel[winner];

  always_comb begin
    own_dout = '0;
    own_doe  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        own_dout = req_dout[8*i +: 8];
        own_doe  = req_doe[8*i +: 8];
      end
    end
  end

`ifdef UIO_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             hold_cnt <= '0;
    else if (state != OWN)  hold_cnt <= '0;
    else                    hold_cnt <= hold_cnt + 8'd1;
  end

  // hold_cnt is 0 in the first OWN cycle, so the limit fires at the end of OWN cycle MAX_HOLD.
  assign forced = (state == OWN) && (hold_cnt == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout <= 1'b0;
    else        timeout <= timeout_d;
  end
`else
  logic unused_hold;
  assign unused_hold = ^8'(MAX_HOLD);
  assign forced      = 1'b0;
  assign timeout     = 1'b0;
`endif

  // NOTE: every sequential element uses non-blocking assignment so all flops update
  // together from pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      winner     <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      turn_cnt   <= '0;
      gnt        <= '0;
      uio_out    <= '0;
      uio_oe     <= '0;
    end else begin
      state   <= state_d;
      winner  <= winner_d;
      gnt     <= gnt_d;
      uio_out <= uio_out_d;
      uio_oe  <= uio_oe_d;
      if (state == IDLE)                        turn_cnt <= 4'(TURN_CYC - 1);
      else if (state == TURN && turn_cnt != '0) turn_cnt <= turn_cnt - 4'd1;
      if (state == OWN && state_d == IDLE)      last_owner <= winner;
    end
  end

  // NOTE: each combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state;
    winner_d = winner;
    case (state)
      IDLE: if (ena && |req) begin
              state_d  = TURN;
              winner_d = rr_pick(req, last_owner);
            end
      TURN: if (!req_own)             state_d = IDLE;
            else if (turn_cnt == '0)  state_d = OWN;
      OWN:  if (rel_own || !req_own || forced) state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Pins only carry owner data while staying in OWN; entry and exit cycles drive zero.
  always_comb begin
    gnt_d     = '0;
    uio_out_d = '0;
    uio_oe_d  = '0;
    timeout_d = 1'b0;
    if (state_d == OWN) gnt_d = NUM_REQ'(1) << winner_d;
    if (state == OWN && state_d == OWN) begin
      uio_out_d = own_dout;
      uio_oe_d  = own_doe;
    end
    if (forced && req_own && !rel_own) timeout_d = 1'b1;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter at default parameters; follows UIO_ARB_TIMEOUT_EN
// to pick the expected hold behaviour.
module tb_uio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  rel = '0;
  logic [7:0]  dout_v [4];
  logic [7:0]  doe_v  [4];
  logic [31:0] req_dout, req_doe;
  logic [3:0]  gnt;
  logic [7:0]  uio_out, uio_oe;
  logic        busy, timeout;

  int total = 0;
  int bad   = 0;

  assign req_dout = {dout_v[3], dout_v[2], dout_v[1], dout_v[0]};
  assign req_doe  = {doe_v[3],  doe_v[2],  doe_v[1],  doe_v[0]};

  uio_bus_arbiter #(.NUM_REQ(4), .TURN_CYC(2), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .rel(rel),
    .req_dout(req_dout), .req_doe(req_doe),
    .gnt(gnt), .uio_out(uio_out), .uio_oe(uio_oe), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  initial begin
    int   exp_order [5];
    int   gap;
    int   n;
    logic oe_clean;
    logic to_early;
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      dout_v[i] = 8'h00;
      doe_v[i]  = 8'h00;
    end

    // Reset with all requests asserted
    req = 4'hF; ena = 1'b1; rst_n = 1'b0;
    repeat (3) tick();
    check("rst_gnt", gnt, 0);
    check("rst_oe", uio_oe, 0);
    check("rst_out", uio_out, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    tick();
    check("first_e0_gnt", gnt, 0);
    check("first_e0_busy", busy, 1);
    tick();
    check("first_e1_gnt", gnt, 0);
    tick();
    check("first_e2_gnt", gnt, 4'b0001);

    // Single owner: requester 1
    req = 4'b0010; dout_v[1] = 8'hA5; doe_v[1] = 8'hFF;
    tick();
    check("r0_exit_gnt", gnt, 0);
    check("r0_exit_busy", busy, 0);
    repeat (3) tick();
    check("r1_gnt", gnt, 4'b0010);
    check("r1_first_oe", uio_oe, 0);
    tick();
    check("r1_out", uio_out, 8'hA5);
    check("r1_oe", uio_oe, 8'hFF);
    rel = 4'b0001;
    tick();
    check("r1_foreign_rel_gnt", gnt, 4'b0010);
    check("r1_foreign_rel_oe", uio_oe, 8'hFF);
    rel = 4'b0010;
    tick();
    rel = 4'b0000; req = 4'b0000;
    check("r1_rel_gnt", gnt, 0);
    check("r1_rel_oe", uio_oe, 0);
    check("r1_rel_out", uio_out, 0);
    check("r1_rel_busy", busy, 0);

    // Asynchronous reset while owning
    req = 4'b0010;
    repeat (4) tick();
    check("async_pre_oe", uio_oe, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", gnt, 0);
    check("async_oe", uio_oe, 0);
    check("async_out", uio_out, 0);
    check("async_busy", busy, 0);

    // Round-robin with all requests held, each owner releasing after 3 cycles
    for (int i = 0; i < 4; i++) begin
      dout_v[i] = 8'h30 + 8'(i);
      doe_v[i]  = 8'hC0 | 8'(i);
    end
    @(posedge clk);
    #1;
    req = 4'hF; rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      gap = 0; oe_clean = 1'b1;
      while (gnt == 4'b0000 && gap < 20) begin
        if (uio_oe != 8'h00) oe_clean = 1'b0;
        gap++;
        tick();
      end
      check($sformatf("rr_gnt_%0d", s), gnt, 32'(1 << exp_order[s]));
      check($sformatf("rr_gap_%0d", s), gap, 3);
      check($sformatf("rr_gap_oe_%0d", s), oe_clean, 1);
      tick();
      check($sformatf("rr_out_%0d", s), uio_out, 8'h30 + 8'(exp_order[s]));
      check($sformatf("rr_oe_%0d", s), uio_oe, 8'hC0 | 8'(exp_order[s]));
      tick();
      rel = 4'(1 << exp_order[s]);
      tick();
      rel = 4'b0000;
      if (s == 4) req = 4'b0000;
      check($sformatf("rr_rel_gnt_%0d", s), gnt, 0);
    end

    // Abort: requester 2 drops during TURN
    req = 4'b0100;
    tick();
    check("abort_turn_busy", busy, 1);
    check("abort_turn_gnt", gnt, 0);
    req = 4'b0000;
    tick();
    check("abort_idle_busy", busy, 0);
    check("abort_idle_gnt", gnt, 0);

    // Gating: ena=0 holds IDLE; afterwards requester 2 must win again over 3
    ena = 1'b0; req = 4'b1100;
    repeat (5) tick();
    check("gate_busy", busy, 0);
    check("gate_gnt", gnt, 0);
    ena = 1'b1;
    tick();
    check("gate_open_busy", busy, 1);
    repeat (2) tick();
    check("gate_winner", gnt, 4'b0100);
    ena = 1'b0;
    tick();
    check("ena_low_own_gnt", gnt, 4'b0100);
    rel = 4'b0100;
    tick();
    rel = 4'b0000; req = 4'b0000; ena = 1'b1;
    check("gate_rel_gnt", gnt, 0);

    // Hold limit: requester 3 holds without releasing, requester 0 waiting
    req = 4'b1001;
    gap = 0;
    while (gnt == 4'b0000 && gap < 20) begin
      gap++;
      tick();
    end
    check("hold_gnt3", gnt, 4'b1000);
    n = 0; to_early = 1'b0;
`ifdef UIO_ARB_TIMEOUT_EN
    while (gnt[3] && n < 120) begin
      if (timeout) to_early = 1'b1;
      n++;
      tick();
    end
    check("to_hold_cycles", n, 8);
    check("to_pulse", timeout, 1);
    check("to_pulse_gnt", gnt, 0);
    check("to_early", to_early, 0);
    tick();
    check("to_pulse_end", timeout, 0);
    gap = 0;
    while (gnt == 4'b0000 && gap < 20) begin
      gap++;
      tick();
    end
    check("to_next_owner", gnt, 4'b0001);
    rel = 4'b0001;
`else
    while (gnt[3] && n < 100) begin
      if (timeout) to_early = 1'b1;
      n++;
      tick();
    end
    check("hold_cycles", n, 100);
    check("hold_still_gnt", gnt, 4'b1000);
    check("hold_no_timeout", to_early, 0);
    check("hold_timeout_now", timeout, 0);
    rel = 4'b1000;
`endif
    tick();
    rel = 4'b0000; req = 4'b0000;
    check("final_gnt", gnt, 0);
    tick();
    check("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
